tohost_monitor: RTL and testbench
=================================

Name: tohost_monitor

Overview:
- Parametrised tohost target for simulation and FPGA self-test tops.
- Accepts tohost write requests from NCH harts/masters, each with a valid/ready handshake.
- Decodes two kinds of write: exit codes and console characters. Buffers console bytes in a FIFO.
- Reports pass/fail/timeout status, and runs a watchdog that the single-hart, exit-only scheme lacked.

Parameters:
- XLEN, 32, tohost data width (32 or 64).
- NCH, 2, number of requesting channels (1..8).
- CON_DEPTH, 8, console FIFO depth, power of 2, at least 2.
- TIMEOUT, 1000000, watchdog limit in cycles; 0 disables the watchdog.
- CNT_W, 32, width of the cycle counter.

Ports:
- CLK  in  1  clock
- RSTn  in  1  asynchronous active-low reset
- ch_valid  in  NCH  per-channel tohost write request
- ch_ready  out  NCH  per-channel accept
- ch_data  in  NCH*XLEN  per-channel write data; channel i occupies [i*XLEN +: XLEN]
- con_valid  out  1  console byte available
- con_ready  in  1  console sink accepts the byte
- con_data  out  8  console byte
- done  out  1  run finished (exit or timeout), sticky
- pass  out  1  exit with code 0
- timeout  out  1  watchdog expired
- exit_code  out  XLEN-1  exit code, i.e. data>>1
- exit_ch  out  max(1,$clog2(NCH))  channel that issued the exit
- cycle_count  out  CNT_W  cycles spent in RUN

Behaviour:
- Reset: all outputs 0. FIFO empty. State RUN. Counter 0.
- Reset mid-operation clears everything, including buffered console bytes.
- Encoding of an accepted write word D:
  - D[0]=1: exit, with code D>>1. pass=1 only when D==1.
  - D[0]=0: console write of byte D[8:1]. D==0 is ignored (accepted, no effect).
- Arbitration: only the lowest-index channel with ch_valid=1 is the candidate. At most one write is accepted per cycle.
- RUN, candidate is an exit: ch_ready for that channel is 1.
- RUN, candidate is a console write: ch_ready is 1 only when the FIFO is not full.
- RUN, all other channels: ch_ready=0.
- DONE: ch_ready is all ones; every write is accepted and discarded.
- Handshake: a transfer occurs when ch_valid & ch_ready are both 1. A channel must hold its data stable while waiting.
- Exit accepted in cycle N:
  - From N+1, done=1, pass, exit_code and exit_ch are valid and frozen. State goes to DONE.
  - The counter freezes at its cycle-N value + 1.
- Console byte accepted in cycle N: con_valid=1 in N+1 at the earliest, in FIFO order.
- FIFO push is blocked when full, even if a pop occurs in the same cycle (no pass-through). A simultaneous push and pop when not full keeps the occupancy unchanged.
- Console drain: a pop occurs when con_valid & con_ready. Draining continues in DONE.
- Watchdog, when TIMEOUT>0:
  - In RUN, cycle_count increments every cycle.
  - When it reaches TIMEOUT-1 with no exit accepted that cycle: next cycle done=1, timeout=1, pass=0, exit_code=0.
  - If an exit and the expiry happen in the same cycle, the exit wins and timeout=0.
- With TIMEOUT=0 the counter saturates at all ones and never expires.
- States: RUN -> DONE on an accepted exit or watchdog expiry. DONE is left only by reset.

Optional Feature:
- Macro TOHOST_SIM_EN.
- When defined, one cycle after done rises, the block $displays one of:
  - "[TOHOST] [PASS] ch %0d"
  - "[TOHOST] [FAIL] ch %0d code %0d"
  - "[TOHOST] [TIMEOUT] %0d cycles"
- It then $writes each console byte as it is popped, and calls $finish once the FIFO is empty in DONE.
- Without the macro: fully synthesizable, with no system tasks. Status is reported on ports only.

Decomposition:
- Package tohost_pkg:
  - state enum {RUN, DONE};
  - EXIT_BIT=0;
  - CHAR_LSB=1, CHAR_MSB=8;
  - a function decode_kind(D) returning {EXIT, CHAR, NOP}.
- Sub-module tohost_fifo: synchronous FIFO, width 8, depth CON_DEPTH.
  - Ports: push/full and pop/empty. Pointers one bit wider than the index, for wrap-around full detection.

Test Plan:
- Ch0 writes 32'h1 -> ch_ready[0]=1 the same cycle; next cycle done=1, pass=1, exit_ch=0, exit_code=0.
- Ch1 writes 32'h0000_000B -> done=1, pass=0, exit_code=5, exit_ch=1. A later write is accepted, but status is unchanged.
- Ch0 writes 'H','i' (D=0x90, 0xD2) with con_ready held at 0 -> con_valid=1 and con_data=0x48 is held. Release con_ready -> 0x48 then 0x69 are popped.
- con_ready=0 and 9 console writes with CON_DEPTH=8 -> the 9th sees ch_ready=0 until one byte is popped. Order is preserved.
- Ch0 and ch1 both valid the same cycle, ch0 console and ch1 exit -> ch0 is accepted first and ch1 the next cycle. Final exit_ch=1.
- TIMEOUT=100 with no writes -> done=1, timeout=1 at cycle 100, cycle_count=100. Repeat with an exit landing on cycle 99 -> timeout=0, pass is taken from the exit.

Source files
------------

// File: rtl/tohost_pkg.sv
// Shared types and decode helper for the tohost monitor.
package tohost_pkg;

    typedef enum logic {
        RUN  = 1'b0,
        DONE = 1'b1
    } state_e;

    typedef enum logic [1:0] {
        EXIT = 2'd0,
        CHAR = 2'd1,
        NOP  = 2'd2
    } kind_e;

    localparam int EXIT_BIT = 0;
    localparam int CHAR_LSB = 1;
    localparam int CHAR_MSB = 8;

    // Callers zero-extend their XLEN-wide word to 64 bits.
    function automatic kind_e decode_kind(input logic [63:0] d);
        if (d[EXIT_BIT]) begin
            return EXIT;
        end else if (d == 64'd0) begin
            return NOP;
        end else begin
            return CHAR;
        end
    endfunction

endpackage

// File: rtl/tohost_fifo.sv
// Byte-wide synchronous FIFO for console characters.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module tohost_fifo #(
    parameter int DEPTH = 8
) (
    input  logic       CLK,
    input  logic       RSTn,
    input  logic       push,
    input  logic [7:0] din,
    output logic       full,
    input  logic       pop,
    output logic [7:0] dout,
    output logic       empty
);
    import tohost_pkg::*;

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic [7:0]  mem_q [DEPTH];
    logic        do_push;
    logic        do_pop;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign dout  = mem_q[rd_ptr_q[AW-1:0]];

    // A full FIFO refuses the push even if a pop frees a slot this cycle.
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= 8'h00;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/tohost_monitor.sv
// Multi-channel tohost target: exit/console decode, console FIFO, watchdog.
// Define TOHOST_SIM_EN to print status/console text and end the simulation.
//
//   state | meaning
//   RUN   | accepting writes, cycle counter running, watchdog armed
//   DONE  | status frozen, all writes accepted and discarded, console drains
module tohost_monitor #(
    parameter int XLEN      = 32,
    parameter int NCH       = 2,
    parameter int CON_DEPTH = 8,
    parameter int TIMEOUT   = 1000000,
    parameter int CNT_W     = 32,
    localparam int CH_W     = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                CLK,
    input  logic                RSTn,
    input  logic [NCH-1:0]      ch_valid,
    output logic [NCH-1:0]      ch_ready,
    input  logic [NCH*XLEN-1:0] ch_data,
    output logic                con_valid,
    input  logic                con_ready,
    output logic [7:0]          con_data,
    output logic                done,
    output logic                pass,
    output logic                timeout,
    output logic [XLEN-2:0]     exit_code,
    output logic [CH_W-1:0]     exit_ch,
    output logic [CNT_W-1:0]    cycle_count
);
    import tohost_pkg::*;

    localparam bit             WD_EN   = (TIMEOUT > 0);
    localparam logic [CNT_W-1:0] WD_LAST = WD_EN ? CNT_W'(TIMEOUT - 1) : '0;

    state_e           state_q, state_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic             timeout_q, timeout_d;
    logic [XLEN-2:0]  exit_code_q, exit_code_d;
    logic [CH_W-1:0]  exit_ch_q, exit_ch_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             cand_vld;
    logic [CH_W-1:0]  cand_idx;
    logic [XLEN-1:0]  cand_data;
    kind_e            cand_kind;
    logic [NCH-1:0]   ready_c;
    logic             accept;
    logic             exit_acc;
    logic             expire;
    logic             fifo_push;
    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_pop;

    // Scan downward so the lowest-index requester ends up as the candidate.
    always_comb begin
        cand_vld  = 1'b0;
        cand_idx  = '0;
        cand_data = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (ch_valid[i]) begin
                cand_vld  = 1'b1;
                cand_idx  = CH_W'(i);
                cand_data = ch_data[i*XLEN +: XLEN];
            end
        end
    end

    assign cand_kind = decode_kind(64'(cand_data));

    always_comb begin
        ready_c = '0;
        if (state_q == DONE) begin
            ready_c = '1;
        end else if (cand_vld) begin
            ready_c[cand_idx] = (cand_kind == CHAR) ? ~fifo_full : 1'b1;
        end
    end

    assign accept    = (state_q == RUN) && cand_vld && ready_c[cand_idx];
    assign exit_acc  = accept && (cand_kind == EXIT);
    assign fifo_push = accept && (cand_kind == CHAR);
    assign expire    = WD_EN && (state_q == RUN) && (cnt_q == WD_LAST) && !exit_acc;

    always_comb begin
        state_d     = state_q;
        done_d      = done_q;
        pass_d      = pass_q;
        timeout_d   = timeout_q;
        exit_code_d = exit_code_q;
        exit_ch_d   = exit_ch_q;
        cnt_d       = cnt_q;
        if (state_q == RUN) begin
            cnt_d = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
            if (exit_acc) begin
                state_d     = DONE;
                done_d      = 1'b1;
                pass_d      = (cand_data == XLEN'(1));
                exit_code_d = cand_data[XLEN-1:1];
                exit_ch_d   = cand_idx;
            end else if (expire) begin
                state_d   = DONE;
                done_d    = 1'b1;
                timeout_d = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q     <= RUN;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            timeout_q   <= 1'b0;
            exit_code_q <= '0;
            exit_ch_q   <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            timeout_q   <= timeout_d;
            exit_code_q <= exit_code_d;
            exit_ch_q   <= exit_ch_d;
            cnt_q       <= cnt_d;
        end
    end

    assign fifo_pop = ~fifo_empty & con_ready;

    tohost_fifo #(
        .DEPTH (CON_DEPTH)
    ) u_fifo (
        .CLK   (CLK),
        .RSTn  (RSTn),
        .push  (fifo_push),
        .din   (cand_data[CHAR_MSB:CHAR_LSB]),
        .full  (fifo_full),
        .pop   (fifo_pop),
        .dout  (con_data),
        .empty (fifo_empty)
    );

    assign ch_ready    = ready_c;
    assign con_valid   = ~fifo_empty;
    assign done        = done_q;
    assign pass        = pass_q;
    assign timeout     = timeout_q;
    assign exit_code   = exit_code_q;
    assign exit_ch     = exit_ch_q;
    assign cycle_count = cnt_q;

`ifdef TOHOST_SIM_EN
    logic done_dly_q;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            done_dly_q <= 1'b0;
        end else begin
            done_dly_q <= done_q;
            if (done_q && !done_dly_q) begin
                if (timeout_q)
                    $display("[TOHOST] [TIMEOUT] %0d cycles", cnt_q);
                else if (pass_q)
                    $display("[TOHOST] [PASS] ch %0d", exit_ch_q);
                else
                    $display("[TOHOST] [FAIL] ch %0d code %0d", exit_ch_q, exit_code_q);
            end
            if (fifo_pop)
                $write("%c", con_data);
            if (done_q && done_dly_q && fifo_empty)
                $finish;
        end
    end
`endif

endmodule

// File: tb/tb_tohost_monitor.sv
// Directed self-checking bench for tohost_monitor (main instance plus a short-watchdog instance).
module tb_tohost_monitor;

    logic        CLK = 1'b0;
    logic        RSTn;

    logic [1:0]  ch_valid;
    logic [1:0]  ch_ready;
    logic [63:0] ch_data;
    logic        con_valid;
    logic        con_ready;
    logic [7:0]  con_data;
    logic        done;
    logic        pass;
    logic        timeout;
    logic [30:0] exit_code;
    logic [0:0]  exit_ch;
    logic [31:0] cycle_count;

    logic        w_valid;
    logic        w_ready;
    logic [31:0] w_data;
    logic        w_con_valid;
    logic        w_con_ready;
    logic [7:0]  w_con_data;
    logic        w_done;
    logic        w_pass;
    logic        w_timeout;
    logic [30:0] w_exit_code;
    logic [0:0]  w_exit_ch;
    logic [31:0] w_cycle_count;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 CLK = ~CLK;

    tohost_monitor #(
        .XLEN(32), .NCH(2), .CON_DEPTH(8), .TIMEOUT(1000000), .CNT_W(32)
    ) u_dut (
        .CLK(CLK), .RSTn(RSTn),
        .ch_valid(ch_valid), .ch_ready(ch_ready), .ch_data(ch_data),
        .con_valid(con_valid), .con_ready(con_ready), .con_data(con_data),
        .done(done), .pass(pass), .timeout(timeout),
        .exit_code(exit_code), .exit_ch(exit_ch), .cycle_count(cycle_count)
    );

    tohost_monitor #(
        .XLEN(32), .NCH(1), .CON_DEPTH(4), .TIMEOUT(100), .CNT_W(32)
    ) u_wdt (
        .CLK(CLK), .RSTn(RSTn),
        .ch_valid(w_valid), .ch_ready(w_ready), .ch_data(w_data),
        .con_valid(w_con_valid), .con_ready(w_con_ready), .con_data(w_con_data),
        .done(w_done), .pass(w_pass), .timeout(w_timeout),
        .exit_code(w_exit_code), .exit_ch(w_exit_ch), .cycle_count(w_cycle_count)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_reset();
        RSTn        = 1'b0;
        ch_valid    = 2'b00;
        ch_data     = 64'd0;
        con_ready   = 1'b0;
        w_valid     = 1'b0;
        w_data      = 32'd0;
        w_con_ready = 1'b0;
        tick();
        tick();
        RSTn = 1'b1;
    endtask

    initial begin
        // Reset state
        do_reset();
        RSTn = 1'b0;
        settle();
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_code", exit_code, 0);
        chk("rst_ch", exit_ch, 0);
        chk("rst_con_valid", con_valid, 0);
        chk("rst_con_data", con_data, 0);
        chk("rst_cnt", cycle_count, 0);
        chk("rst_ready", ch_ready, 0);
        RSTn = 1'b1;

        // Ch0 exit with pass
        do_reset();
        ch_valid = 2'b01;
        ch_data  = 64'h0000_0000_0000_0001;
        settle();
        chk("t1_ready", ch_ready, 2'b01);
        tick();
        ch_valid = 2'b00;
        chk("t1_done", done, 1);
        chk("t1_pass", pass, 1);
        chk("t1_ch", exit_ch, 0);
        chk("t1_code", exit_code, 0);
        chk("t1_timeout", timeout, 0);
        chk("t1_cnt", cycle_count, 1);
        tick();
        chk("t1_cnt_frozen", cycle_count, 1);
        chk("t1_ready_done", ch_ready, 2'b11);

        // Ch1 exit with failure code 5, later writes ignored
        do_reset();
        ch_valid = 2'b10;
        ch_data  = 64'h0000_000B_0000_0000;
        settle();
        chk("t2_ready", ch_ready, 2'b10);
        tick();
        ch_valid = 2'b00;
        chk("t2_done", done, 1);
        chk("t2_pass", pass, 0);
        chk("t2_code", exit_code, 5);
        chk("t2_ch", exit_ch, 1);
        ch_valid = 2'b01;
        ch_data  = 64'h0000_0000_0000_0001;
        settle();
        chk("t2_late_ready", ch_ready, 2'b11);
        tick();
        ch_data = 64'h0000_0000_0000_0090;
        tick();
        ch_valid = 2'b00;
        chk("t2_late_pass", pass, 0);
        chk("t2_late_code", exit_code, 5);
        chk("t2_late_ch", exit_ch, 1);
        chk("t2_late_con", con_valid, 0);

        // Large exit word and NOP write
        do_reset();
        ch_valid = 2'b01;
        ch_data  = 64'h0000_0000_0000_0000;
        settle();
        chk("nop_ready", ch_ready, 2'b01);
        tick();
        chk("nop_done", done, 0);
        chk("nop_con", con_valid, 0);
        ch_data = 64'h0000_0000_FFFF_FFFF;
        tick();
        ch_valid = 2'b00;
        chk("big_done", done, 1);
        chk("big_pass", pass, 0);
        chk("big_code", exit_code, 31'h7FFF_FFFF);
        chk("big_cnt", cycle_count, 2);

        // "Hi" held with con_ready low, then drained
        do_reset();
        ch_valid = 2'b01;
        ch_data  = 64'h0000_0000_0000_0090;
        settle();
        chk("hi_ready", ch_ready, 2'b01);
        tick();
        chk("hi_valid1", con_valid, 1);
        chk("hi_data1", con_data, 8'h48);
        ch_data = 64'h0000_0000_0000_00D2;
        tick();
        ch_valid = 2'b00;
        tick();
        chk("hi_hold", con_data, 8'h48);
        con_ready = 1'b1;
        tick();
        chk("hi_data2", con_data, 8'h69);
        chk("hi_valid2", con_valid, 1);
        tick();
        chk("hi_empty", con_valid, 0);
        chk("hi_done", done, 0);
        con_ready = 1'b0;

        // Fill FIFO, ninth write stalls until a pop
        do_reset();
        ch_valid = 2'b01;
        for (int i = 0; i < 8; i++) begin
            ch_data = 64'(({8'h30} + 8'(i)) << 1);
            settle();
            chk("fill_ready", ch_ready, 2'b01);
            tick();
        end
        ch_data = 64'h0000_0000_0000_0070;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("full_stall", ch_ready, 2'b00);
            tick();
        end
        con_ready = 1'b1;
        settle();
        chk("full_pop_noshort", ch_ready, 2'b00);
        tick();
        con_ready = 1'b0;
        settle();
        chk("full_after_pop", ch_ready, 2'b01);
        chk("full_head", con_data, 8'h31);
        tick();
        ch_valid  = 2'b00;
        con_ready = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            chk("drain_order", con_data, 64'(8'h30 + 8'(k)));
            tick();
        end
        chk("drain_empty", con_valid, 0);
        con_ready = 1'b0;

        // Both channels: ch0 console first, ch1 exit next cycle
        do_reset();
        ch_valid = 2'b11;
        ch_data  = 64'h0000_0003_0000_0090;
        settle();
        chk("arb_ready0", ch_ready, 2'b01);
        tick();
        ch_valid = 2'b10;
        settle();
        chk("arb_ready1", ch_ready, 2'b10);
        chk("arb_notdone", done, 0);
        tick();
        ch_valid = 2'b00;
        chk("arb_done", done, 1);
        chk("arb_ch", exit_ch, 1);
        chk("arb_code", exit_code, 1);
        chk("arb_pass", pass, 0);
        chk("arb_con", con_data, 8'h48);
        con_ready = 1'b1;
        tick();
        chk("arb_drain_done", con_valid, 0);
        con_ready = 1'b0;

        // Watchdog expiry with no writes
        do_reset();
        for (int i = 0; i < 99; i++) tick();
        chk("wd_cnt99", w_cycle_count, 99);
        chk("wd_not_yet", w_done, 0);
        tick();
        chk("wd_done", w_done, 1);
        chk("wd_timeout", w_timeout, 1);
        chk("wd_pass", w_pass, 0);
        chk("wd_code", w_exit_code, 0);
        chk("wd_cnt", w_cycle_count, 100);
        tick();
        chk("wd_cnt_frozen", w_cycle_count, 100);
        chk("main_no_timeout", timeout, 0);

        // Exit lands on the expiry cycle and wins
        do_reset();
        for (int i = 0; i < 99; i++) tick();
        w_valid = 1'b1;
        w_data  = 32'h0000_0001;
        settle();
        chk("wd_race_ready", w_ready, 1);
        tick();
        w_valid = 1'b0;
        chk("wd_race_done", w_done, 1);
        chk("wd_race_timeout", w_timeout, 0);
        chk("wd_race_pass", w_pass, 1);
        chk("wd_race_cnt", w_cycle_count, 100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
